// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_if
// Purpose  : Bundles the MEM/WB write-back inputs, the decode read ports and
//            the write-back status outputs of wb_regfile.
// Modports : master - the pipeline side (drives Wr_*, Ra, Rb)
//            slave  - the register file (drives busA, busB, wb_data,
//                     wb_valid, wr_count)
// Revision : 1.0 - initial release
// ============================================================================
interface wb_regfile_if;
    // Write-back bundle launched by the MEM/WB register on the falling edge
    logic [31:0] Wr_npc;
    logic [31:0] Wr_dataout;
    logic [31:0] Wr_ALUout;
    logic [4:0]  Wr_Rw;
    logic [1:0]  Wr_MemtoReg;
    logic        Wr_RegWr;
    // Decode-stage read indices
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    // Read data and write-back status
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic [31:0] wr_count;

    modport master (
        output Wr_npc, Wr_dataout, Wr_ALUout, Wr_Rw, Wr_MemtoReg, Wr_RegWr,
        output Ra, Rb,
        input  busA, busB, wb_data, wb_valid, wr_count
    );

    modport slave (
        input  Wr_npc, Wr_dataout, Wr_ALUout, Wr_Rw, Wr_MemtoReg, Wr_RegWr,
        input  Ra, Rb,
        output busA, busB, wb_data, wb_valid, wr_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Write-back stage plus 32x32 general register file. Selects the
//            write-back value from the MEM/WB bundle, commits it on the rising
//            clock edge, serves two zero-latency read ports with same-cycle
//            write-through bypass, and counts committed writes.
// Ports    : clk  - clock, state updates on the rising edge
//            rst  - asynchronous active-high reset
//            bus  - wb_regfile_if.slave:
//                   in : Wr_npc, Wr_dataout, Wr_ALUout, Wr_Rw, Wr_MemtoReg,
//                        Wr_RegWr, Ra, Rb
//                   out: busA, busB, wb_data, wb_valid, wr_count
// Params   : SP_INIT - reset value of register 29 ($sp)
//            GP_INIT - reset value of register 28 ($gp)
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
    parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
    input  wire logic   clk,
    input  wire logic   rst,
    wb_regfile_if.slave bus
);

    localparam logic [1:0] c_SEL_ALU = 2'b00;
    localparam logic [1:0] c_SEL_MEM = 2'b01;
    localparam logic [1:0] c_SEL_NPC = 2'b10;
    localparam logic [4:0] c_REG_ZERO = 5'd0;
    localparam int         c_REG_GP   = 28;
    localparam int         c_REG_SP   = 29;

    logic [31:0] r_regs [0:31];
    logic [31:0] r_wr_count;

    logic [31:0] w_wb_data;
    logic        w_wb_valid;
    logic [31:0] w_bus_a;
    logic [31:0] w_bus_b;

    // Write-back source select; the reserved code falls back to the ALU result.
    always_comb begin
        w_wb_data = bus.Wr_ALUout;
        case (bus.Wr_MemtoReg)
            c_SEL_ALU: w_wb_data = bus.Wr_ALUout;
            c_SEL_MEM: w_wb_data = bus.Wr_dataout;
            c_SEL_NPC: w_wb_data = bus.Wr_npc;
            default:   w_wb_data = bus.Wr_ALUout;
        endcase
    end

    // Writes to $zero never commit; reset masks the enable so nothing is
    // reported or bypassed while the file is being reinitialised.
    assign w_wb_valid = bus.Wr_RegWr && (bus.Wr_Rw != c_REG_ZERO) && !rst;

    // Read port A: $zero, then the in-flight write, then storage.
    always_comb begin
        w_bus_a = r_regs[bus.Ra];
        if (bus.Ra == c_REG_ZERO) begin
            w_bus_a = 32'h0;
        end else if (w_wb_valid && (bus.Wr_Rw == bus.Ra)) begin
            w_bus_a = w_wb_data;
        end
    end

    // Read port B, independent of port A.
    always_comb begin
        w_bus_b = r_regs[bus.Rb];
        if (bus.Rb == c_REG_ZERO) begin
            w_bus_b = 32'h0;
        end else if (w_wb_valid && (bus.Wr_Rw == bus.Rb)) begin
            w_bus_b = w_wb_data;
        end
    end

    // Register storage. Entry 0 is held at zero and is never read out, since
    // both read ports decode index 0 to a constant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                if (i == c_REG_GP) begin
                    r_regs[i] <= GP_INIT;
                end else if (i == c_REG_SP) begin
                    r_regs[i] <= SP_INIT;
                end else begin
                    r_regs[i] <= 32'h0;
                end
            end
        end else if (w_wb_valid) begin
            r_regs[bus.Wr_Rw] <= w_wb_data;
        end
    end

    // Committed-write counter; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_count <= 32'h0;
        end else if (w_wb_valid) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign bus.busA     = w_bus_a;
    assign bus.busB     = w_bus_b;
    assign bus.wb_data  = w_wb_data;
    assign bus.wb_valid = w_wb_valid;
    assign bus.wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Self-checking bench for wb_regfile: reset state, source select,
//            bypass, $zero handling, back-to-back writes and counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] model_cnt;

    wb_regfile_if bus ();

    wb_regfile #(
        .SP_INIT(32'h0000_3FFC),
        .GP_INIT(32'h0000_1800)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] dout;
        logic [31:0] npc;
        logic [4:0]  rw;
        logic        we;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_wb;
        logic        exp_valid;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] post_a;
        logic [31:0] post_b;
    } vec_t;

    typedef struct {
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] cnt;
    } sb_t;

    vec_t vecs [8];
    sb_t  sbq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] dout, input logic [31:0] npc,
                         input logic [4:0] rw, input logic we,
                         input logic [4:0] ra, input logic [4:0] rb);
        bus.Wr_MemtoReg = sel;
        bus.Wr_ALUout   = alu;
        bus.Wr_dataout  = dout;
        bus.Wr_npc      = npc;
        bus.Wr_Rw       = rw;
        bus.Wr_RegWr    = we;
        bus.Ra          = ra;
        bus.Rb          = rb;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t         sb;
        logic [31:0] exp_r;
        total     = 0;
        bad       = 0;
        model_cnt = 32'h0;

        //            sel    alu            dout      npc        rw    we    ra    rb    exp_wb         v     exp_a          exp_b          post_a         post_b
        vecs[0] = '{2'b00, 32'hA,         32'hD,    32'h3004,  5'd8, 1'b1, 5'd8, 5'd0, 32'hA,         1'b1, 32'hA,         32'h0,         32'hA,         32'h0};
        vecs[1] = '{2'b01, 32'hA,         32'hD,    32'h3004,  5'd8, 1'b1, 5'd8, 5'd0, 32'hD,         1'b1, 32'hD,         32'h0,         32'hD,         32'h0};
        vecs[2] = '{2'b10, 32'hA,         32'hD,    32'h3004,  5'd8, 1'b1, 5'd8, 5'd0, 32'h3004,      1'b1, 32'h3004,      32'h0,         32'h3004,      32'h0};
        vecs[3] = '{2'b11, 32'hA,         32'hD,    32'h3004,  5'd8, 1'b1, 5'd8, 5'd0, 32'hA,         1'b1, 32'hA,         32'h0,         32'hA,         32'h0};
        vecs[4] = '{2'b00, 32'h1234,      32'h0,    32'h0,     5'd9, 1'b1, 5'd9, 5'd9, 32'h1234,      1'b1, 32'h1234,      32'h1234,      32'h1234,      32'h1234};
        vecs[5] = '{2'b00, 32'hFFFF_FFFF, 32'h0,    32'h0,     5'd0, 1'b1, 5'd0, 5'd8, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'hA,         32'h0,         32'hA};
        vecs[6] = '{2'b01, 32'h1,         32'h55,   32'h2,     5'd10, 1'b0, 5'd10, 5'd28, 32'h55,     1'b0, 32'h0,         32'h1800,      32'h0,         32'h1800};
        vecs[7] = '{2'b10, 32'h1,         32'h2,    32'h4000,  5'd29, 1'b1, 5'd29, 5'd31, 32'h4000,   1'b1, 32'h4000,      32'h0,         32'h4000,      32'h0};

        // ---------------- reset state, with a write pending ----------------
        rst = 1'b0;
        drive(2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd5, 1'b1, 5'd0, 5'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
        chk("rst_wr_count", bus.wr_count, 32'h0);
        for (int i = 0; i < 32; i++) begin
            bus.Ra = 5'(i);
            #1;
            exp_r = (i == 28) ? 32'h1800 : (i == 29) ? 32'h3FFC : 32'h0;
            chk($sformatf("rst_reg%0d", i), bus.busA, exp_r);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.Wr_RegWr = 1'b0;

        // Write reg7, then reset mid-cycle with a reg5 write pending.
        @(negedge clk);
        drive(2'b00, 32'h77, 32'h0, 32'h0, 5'd7, 1'b1, 5'd7, 5'd5);
        @(posedge clk); #1;
        bus.Wr_RegWr = 1'b0;
        #1;
        chk("pre_rst_reg7", bus.busA, 32'h77);
        chk("pre_rst_cnt", bus.wr_count, 32'h1);
        #1;
        drive(2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd5, 1'b1, 5'd7, 5'd5);
        rst = 1'b1;
        #1;
        chk("async_rst_cnt", bus.wr_count, 32'h0);
        chk("async_rst_reg7", bus.busA, 32'h0);
        chk("async_rst_valid", {31'h0, bus.wb_valid}, 32'h0);
        @(posedge clk); #1;
        chk("rst_reg5", bus.busB, 32'h0);
        chk("rst_hold_cnt", bus.wr_count, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.Wr_RegWr = 1'b0;
        #1;
        chk("post_rst_reg5", bus.busB, 32'h0);

        // ---------------- table-driven vectors with scoreboard -------------
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].sel, vecs[i].alu, vecs[i].dout, vecs[i].npc,
                  vecs[i].rw, vecs[i].we, vecs[i].ra, vecs[i].rb);
            #2;
            chk($sformatf("v%0d_wb_data", i), bus.wb_data, vecs[i].exp_wb);
            chk($sformatf("v%0d_wb_valid", i), {31'h0, bus.wb_valid}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("v%0d_busA", i), bus.busA, vecs[i].exp_a);
            chk($sformatf("v%0d_busB", i), bus.busB, vecs[i].exp_b);
            if (vecs[i].we && (vecs[i].rw != 5'd0)) model_cnt = model_cnt + 32'd1;
            sbq.push_back('{vecs[i].ra, vecs[i].rb, vecs[i].post_a, vecs[i].post_b, model_cnt});
            @(posedge clk); #1;
            bus.Wr_RegWr = 1'b0;
            sb = sbq.pop_front();
            bus.Ra = sb.ra;
            bus.Rb = sb.rb;
            #1;
            chk($sformatf("v%0d_post_busA", i), bus.busA, sb.a);
            chk($sformatf("v%0d_post_busB", i), bus.busB, sb.b);
            chk($sformatf("v%0d_wr_count", i), bus.wr_count, sb.cnt);
        end

        // ---------------- consecutive writes to reg3 -----------------------
        @(negedge clk);
        drive(2'b00, 32'h11, 32'h0, 32'h0, 5'd3, 1'b1, 5'd3, 5'd0);
        @(negedge clk);
        drive(2'b00, 32'h22, 32'h0, 32'h0, 5'd3, 1'b0, 5'd3, 5'd0);
        #1;
        chk("b2b_old", bus.busA, 32'h11);
        bus.Wr_RegWr = 1'b1;
        #1;
        chk("b2b_bypass", bus.busA, 32'h22);
        @(posedge clk); #1;
        bus.Wr_RegWr = 1'b0;
        #1;
        chk("b2b_new", bus.busA, 32'h22);
        model_cnt = model_cnt + 32'd2;
        chk("b2b_cnt", bus.wr_count, model_cnt);

        // ---------------- counter wrap ---------------------------------------
        @(negedge clk);
        dut.r_wr_count = 32'hFFFF_FFFF;
        #1;
        chk("wrap_preload", bus.wr_count, 32'hFFFF_FFFF);
        drive(2'b00, 32'h5, 32'h0, 32'h0, 5'd12, 1'b1, 5'd12, 5'd0);
        @(posedge clk); #1;
        bus.Wr_RegWr = 1'b0;
        #1;
        chk("wrap_cnt", bus.wr_count, 32'h0);
        chk("wrap_reg12", bus.busA, 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
